// File: rtl/coil_pwm_ctl.sv
// Hysteretic peak/valley current-mode PWM controller for the launch coil.
// Closes the loop on the 12-bit coil current estimate and drains the coil before reporting done.
module coil_pwm_ctl #(
   parameter int                MIN_ON  = 8,
   parameter int                MIN_OFF = 8,
   parameter int                MAX_ON  = 480,
   parameter logic signed [11:0] ILIM   = 12'sd1845
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        fault_clr,
   input  logic [23:0] run_len,
   input  logic [11:0] ipk,
   input  logic [11:0] ivl,
   input  logic [11:0] iest_coil,
   output logic        pwm,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        cfg_err,
   output logic        maxon_seen,
   output logic [15:0] pulse_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ON,
      S_OFF,
      S_DRAIN,
      S_FAULT
   } state_t;

   localparam logic [15:0]        MIN_ON_M1  = 16'(MIN_ON - 1);
   localparam logic [15:0]        MIN_OFF_M1 = 16'(MIN_OFF - 1);
   localparam logic [15:0]        MAX_ON_M1  = 16'(MAX_ON - 1);
   localparam logic [15:0]        MIN_OFF_LD = 16'(MIN_OFF);
   localparam logic signed [12:0] ILIM_S     = {ILIM[11], ILIM};

   state_t             state;
   state_t             state_nxt;
   logic [15:0]        on_cnt;
   logic [15:0]        off_cnt;
   logic [23:0]        run_tmr;

   logic signed [11:0] i_raw;
   logic signed [12:0] i_meas;
   logic signed [12:0] ipk_s;
   logic signed [12:0] ivl_s;

   logic over_i;
   logic on_max_hit;
   logic on_exit;
   logic off_ready;
   logic run_done;
   logic start_ok;
   logic start_bad;
   logic accept;
   logic reject;

   // The estimate arrives offset-binary-like; flipping the low 11 bits yields signed DN.
   assign i_raw  = iest_coil ^ 12'h7FF;
   assign i_meas = {i_raw[11], i_raw};
   assign ipk_s  = {1'b0, ipk};
   assign ivl_s  = {1'b0, ivl};

   assign over_i     = (i_meas >= ILIM_S);
   assign on_max_hit = (on_cnt == MAX_ON_M1);
   assign on_exit    = on_max_hit | ((on_cnt >= MIN_ON_M1) & (i_meas >= ipk_s));
   assign off_ready  = (off_cnt >= MIN_OFF_M1) & (i_meas <= ivl_s);
   assign run_done   = (run_tmr == 24'd0);
   assign start_ok   = start & ~abort & (ipk > ivl);
   assign start_bad  = start & ~abort & (ipk <= ivl);
   assign accept     = (state == S_IDLE) & ~over_i & start_ok;
   assign reject     = (state == S_IDLE) & ~over_i & start_bad;

   // Overcurrent outranks every other transition, including abort and fault_clr.
   always_comb begin
      state_nxt = state;
      if (over_i) begin
         state_nxt = S_FAULT;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  state_nxt = (run_len == 24'd0) ? S_DRAIN : S_OFF;
               end
            end
            S_ON: begin
               if (abort) begin
                  state_nxt = S_DRAIN;
               end else if (on_exit) begin
                  state_nxt = S_OFF;
               end
            end
            S_OFF: begin
               if (abort || run_done) begin
                  state_nxt = S_DRAIN;
               end else if (off_ready) begin
                  state_nxt = S_ON;
               end
            end
            S_DRAIN: begin
               if (i_meas <= 13'sd0) begin
                  state_nxt = S_IDLE;
               end
            end
            S_FAULT: begin
               if (fault_clr) begin
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs decode the next state so pwm tracks state==ON with no extra lag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         pwm        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         cfg_err    <= 1'b0;
         maxon_seen <= 1'b0;
         pulse_cnt  <= 16'd0;
         on_cnt     <= 16'd0;
         off_cnt    <= 16'd0;
         run_tmr    <= 24'd0;
      end else begin
         state <= state_nxt;
         pwm   <= (state_nxt == S_ON);
         busy  <= (state_nxt == S_ON) || (state_nxt == S_OFF) || (state_nxt == S_DRAIN);
         fault <= (state_nxt == S_FAULT);
         done  <= (state == S_DRAIN) && (state_nxt == S_IDLE);

         if (state != S_ON) begin
            on_cnt <= 16'd0;
         end else if (on_cnt != 16'hFFFF) begin
            on_cnt <= on_cnt + 16'd1;
         end

         // Preloading MIN_OFF while idle lets the first pulse start immediately after start.
         if (state == S_IDLE) begin
            off_cnt <= MIN_OFF_LD;
         end else if (state == S_ON) begin
            off_cnt <= 16'd0;
         end else if ((state == S_OFF) && (off_cnt != 16'hFFFF)) begin
            off_cnt <= off_cnt + 16'd1;
         end

         if (accept) begin
            run_tmr <= run_len;
         end else if (((state == S_ON) || (state == S_OFF)) && !run_done) begin
            run_tmr <= run_tmr - 24'd1;
         end

         if (accept) begin
            cfg_err <= 1'b0;
         end else if (reject) begin
            cfg_err <= 1'b1;
         end

         if (accept) begin
            maxon_seen <= 1'b0;
         end else if ((state == S_ON) && (state_nxt == S_OFF) && on_max_hit) begin
            maxon_seen <= 1'b1;
         end

         if (accept) begin
            pulse_cnt <= 16'd0;
         end else if ((state == S_OFF) && (state_nxt == S_ON) && (pulse_cnt != 16'hFFFF)) begin
            pulse_cnt <= pulse_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_coil_pwm_ctl.sv
// Closed-loop bench for coil_pwm_ctl: a ramp coil plant driven by a timestamp-based reference model.
module tb_coil_pwm_ctl;

   localparam int MIN_ON  = 8;
   localparam int MIN_OFF = 8;
   localparam int MAX_ON  = 480;
   localparam int ILIM    = 1845;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        start     = 1'b0;
   logic        abort     = 1'b0;
   logic        fault_clr = 1'b0;
   logic [23:0] run_len   = 24'd0;
   logic [11:0] ipk       = 12'd0;
   logic [11:0] ivl       = 12'd0;
   logic [11:0] iest_coil = 12'h7FF;
   logic        pwm;
   logic        busy;
   logic        done;
   logic        fault;
   logic        cfg_err;
   logic        maxon_seen;
   logic [15:0] pulse_cnt;

   coil_pwm_ctl #(
      .MIN_ON (MIN_ON),
      .MIN_OFF(MIN_OFF),
      .MAX_ON (MAX_ON),
      .ILIM   (12'sd1845)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .fault_clr (fault_clr),
      .run_len   (run_len),
      .ipk       (ipk),
      .ivl       (ivl),
      .iest_coil (iest_coil),
      .pwm       (pwm),
      .busy      (busy),
      .done      (done),
      .fault     (fault),
      .cfg_err   (cfg_err),
      .maxon_seen(maxon_seen),
      .pulse_cnt (pulse_cnt)
   );

   always #5 clk = ~clk;

   typedef enum int {P_IDLE, P_ON, P_OFF, P_DRAIN, P_FAULT} phase_t;

   phase_t ph         = P_IDLE;
   longint edge_no    = 0;
   longint start_edge = 0;
   longint on_since   = 0;
   longint off_since  = 0;
   longint run_n      = 0;
   int     pulses     = 0;
   bit     m_cfg      = 1'b0;
   bit     m_maxon    = 1'b0;
   bit     m_done     = 1'b0;

   int cur      = 0;
   int up_rate  = 4;
   int dn_rate  = 2;
   bit hold     = 1'b0;
   int hold_val = 0;

   int   vectors     = 0;
   int   miscompares = 0;
   int   done_seen   = 0;
   int   hi_len      = 0;
   int   lo_len      = 1000;
   int   min_hi      = 1 << 30;
   int   min_lo      = 1 << 30;
   int   last_hi     = 0;
   logic pwm_prev    = 1'b0;

   function automatic int meas();
      logic signed [11:0] t;
      t = iest_coil ^ 12'h7FF;
      return int'(t);
   endfunction

   task automatic model_reset();
      ph      = P_IDLE;
      pulses  = 0;
      m_cfg   = 1'b0;
      m_maxon = 1'b0;
      m_done  = 1'b0;
   endtask

   // Behaviour expressed as elapsed times since each phase began, not as counters.
   task automatic model_step();
      int     im;
      phase_t np;
      longint dur;
      im      = meas();
      np      = ph;
      m_done  = 1'b0;
      edge_no = edge_no + 1;
      if (im >= ILIM) begin
         np = P_FAULT;
      end else begin
         case (ph)
            P_IDLE: begin
               if (start && !abort) begin
                  if (ipk <= ivl) begin
                     m_cfg = 1'b1;
                  end else begin
                     m_cfg      = 1'b0;
                     m_maxon    = 1'b0;
                     pulses     = 0;
                     start_edge = edge_no;
                     run_n      = longint'(run_len);
                     off_since  = edge_no - MIN_OFF;
                     np         = (run_len == 24'd0) ? P_DRAIN : P_OFF;
                  end
               end
            end
            P_ON: begin
               dur = edge_no - on_since;
               if (abort) begin
                  np = P_DRAIN;
               end else if (dur >= MAX_ON) begin
                  np      = P_OFF;
                  m_maxon = 1'b1;
               end else if (dur >= MIN_ON && im >= int'(ipk)) begin
                  np = P_OFF;
               end
               if (np == P_OFF) off_since = edge_no;
            end
            P_OFF: begin
               dur = edge_no - off_since;
               if (abort || (edge_no - start_edge > run_n)) begin
                  np = P_DRAIN;
               end else if (dur >= MIN_OFF && im <= int'(ivl)) begin
                  np       = P_ON;
                  on_since = edge_no;
                  if (pulses < 65535) pulses++;
               end
            end
            P_DRAIN: begin
               if (im <= 0) begin
                  np     = P_IDLE;
                  m_done = 1'b1;
               end
            end
            P_FAULT: begin
               if (fault_clr) np = P_IDLE;
            end
            default: np = P_IDLE;
         endcase
      end
      ph = np;
   endtask

   function automatic logic [21:0] expected_vec();
      return {ph == P_ON, (ph == P_ON) || (ph == P_OFF) || (ph == P_DRAIN), m_done,
              ph == P_FAULT, m_cfg, m_maxon, 16'(pulses)};
   endfunction

   function automatic logic [21:0] observed_vec();
      return {pwm, busy, done, fault, cfg_err, maxon_seen, pulse_cnt};
   endfunction

   task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s at edge %0d: observed %h expected %h", tag, edge_no, obs, exp);
      end
   endtask

   task automatic reset_trackers();
      done_seen = 0;
      hi_len    = 0;
      lo_len    = 1000;
      min_hi    = 1 << 30;
      min_lo    = 1 << 30;
      last_hi   = 0;
      pwm_prev  = pwm;
   endtask

   task automatic track_pwm();
      if (pwm == pwm_prev) begin
         if (pwm) hi_len++;
         else     lo_len++;
      end else if (pwm) begin
         if (lo_len < min_lo) min_lo = lo_len;
         hi_len = 1;
      end else begin
         last_hi = hi_len;
         if (hi_len < min_hi) min_hi = hi_len;
         lo_len = 1;
      end
      pwm_prev = pwm;
      if (done) done_seen++;
   endtask

   task automatic set_current(input int v);
      cur       = v;
      iest_coil = 12'(v) ^ 12'h7FF;
   endtask

   task automatic plant_update();
      if (hold) begin
         cur = hold_val;
      end else begin
         cur += (ph == P_ON) ? up_rate : -dn_rate;
         if (cur < -100) cur = -100;
         if (cur > 2047) cur = 2047;
      end
      iest_coil = 12'(cur) ^ 12'h7FF;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check(tag, observed_vec(), expected_vec());
      track_pwm();
      start     = 1'b0;
      fault_clr = 1'b0;
      plant_update();
   endtask

   task automatic run_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic run_until(input phase_t target, input int budget, input string tag);
      int n;
      n = 0;
      while (ph != target && n < budget) begin
         tick(tag);
         n++;
      end
      if (ph != target) begin
         miscompares++;
         $error("[TB] FAIL %s: timeout after %0d cycles, observed phase %0d required %0d",
                tag, budget, ph, target);
      end
   endtask

   task automatic apply_stimulus(input int pk, input int vl, input int len, input int up, input int dn);
      ipk     = 12'(pk);
      ivl     = 12'(vl);
      run_len = 24'(len);
      up_rate = up;
      dn_rate = dn;
      start   = 1'b1;
   endtask

   initial begin
      set_current(0);
      #2;
      check("reset_init", observed_vec(), 22'd0);
      @(negedge clk);
      check("reset_init_held", observed_vec(), 22'd0);
      reset = 1'b1;
      run_cycles(3, "idle");

      $display("[TB] nominal run");
      reset_trackers();
      apply_stimulus(410, 205, 4800, 4, 2);
      run_until(P_DRAIN, 6000, "nominal");
      run_until(P_IDLE, 2000, "nominal_drain");
      check("nominal_done_cnt", 22'(done_seen), 22'd1);
      check("nominal_pulses", 22'(pulse_cnt > 16'd10), 22'd1);

      $display("[TB] min on/off times");
      reset_trackers();
      apply_stimulus(206, 205, 1000, 20, 20);
      run_until(P_DRAIN, 2000, "mintime");
      run_until(P_IDLE, 500, "mintime_drain");
      check("min_on_time", 22'(min_hi >= MIN_ON), 22'd1);
      check("min_off_time", 22'(min_lo >= MIN_OFF), 22'd1);

      $display("[TB] max on time");
      reset_trackers();
      hold     = 1'b1;
      hold_val = 100;
      set_current(100);
      apply_stimulus(410, 205, 1500, 4, 2);
      run_until(P_ON, 20, "maxon_enter");
      run_until(P_OFF, 600, "maxon_hold");
      check("maxon_len", 22'(last_hi), 22'd480);
      check("maxon_flag", 22'(maxon_seen), 22'd1);
      hold_val = 0;
      abort    = 1'b1;
      tick("maxon_abort");
      abort = 1'b0;
      run_until(P_IDLE, 50, "maxon_drain");

      $display("[TB] overcurrent");
      hold = 1'b0;
      set_current(0);
      apply_stimulus(410, 205, 3000, 4, 2);
      run_until(P_ON, 20, "ovc_enter");
      run_cycles(3, "ovc_on");
      hold     = 1'b1;
      hold_val = 1900;
      set_current(1900);
      tick("ovc_trip");
      check("ovc_fault_pwm", 22'({fault, pwm}), 22'b10);
      fault_clr = 1'b1;
      tick("ovc_clr_high");
      check("ovc_clr_high", 22'(fault), 22'd1);
      start = 1'b1;
      tick("ovc_start");
      check("ovc_start_ignored", 22'({fault, busy}), 22'b10);
      hold_val = 0;
      set_current(0);
      fault_clr = 1'b1;
      tick("ovc_clr_low");
      check("ovc_cleared", 22'({fault, busy, done}), 22'd0);
      hold = 1'b0;

      $display("[TB] config and abort");
      apply_stimulus(300, 300, 1000, 4, 2);
      tick("cfg_bad");
      check("cfg_err_set", 22'({cfg_err, busy}), 22'b10);
      apply_stimulus(410, 205, 1000, 4, 2);
      abort = 1'b1;
      tick("start_abort");
      check("start_abort_idle", 22'(busy), 22'd0);
      abort = 1'b0;
      apply_stimulus(410, 205, 0, 4, 2);
      tick("runlen0");
      check("runlen0_busy", 22'(busy), 22'd1);
      tick("runlen0_done");
      check("runlen0_done", 22'(done), 22'd1);
      reset_trackers();
      set_current(0);
      apply_stimulus(410, 205, 3000, 4, 2);
      run_until(P_ON, 20, "abort_on");
      run_until(P_OFF, 200, "abort_off");
      abort = 1'b1;
      tick("abort_hit");
      abort = 1'b0;
      run_until(P_IDLE, 500, "abort_drain");
      check("abort_done_cnt", 22'(done_seen), 22'd1);

      $display("[TB] randomized runs");
      for (int r = 0; r < 6; r++) begin
         int pk;
         int vl;
         int len;
         pk  = int'($urandom_range(1400, 300));
         vl  = int'($urandom_range(pk - 50, 100));
         len = int'($urandom_range(1500, 300));
         apply_stimulus(pk, vl, len, int'($urandom_range(20, 1)), int'($urandom_range(20, 1)));
         run_cycles(int'($urandom_range(len / 2, 50)), "rand_run");
         pk  = int'($urandom_range(1400, vl + 10));
         ipk = 12'(pk);
         if ($urandom_range(1, 0) == 1) begin
            abort = 1'b1;
            tick("rand_abort");
            abort = 1'b0;
         end
         run_until(P_DRAIN, 3000, "rand_to_drain");
         run_until(P_IDLE, 5000, "rand_to_idle");
      end

      $display("[TB] async reset mid-ON");
      set_current(0);
      apply_stimulus(410, 205, 3000, 4, 2);
      run_until(P_ON, 20, "areset_enter");
      run_cycles(4, "areset_on");
      #2;
      reset = 1'b0;
      #1;
      check("areset_now", observed_vec(), 22'd0);
      model_reset();
      set_current(0);
      @(posedge clk);
      @(negedge clk);
      check("areset_held", observed_vec(), 22'd0);
      #2;
      reset = 1'b1;
      run_cycles(5, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/coil_pwm_ctl.md
Name: coil_pwm_ctl

Overview:
- Hysteretic peak/valley current-mode controller that generates the `pwm` input of the coil current model from that model's 12-bit estimated coil current.
- Sits between the launch sequencer (start/abort/run length) and the power stage, closing the loop on the 48 MHz model estimate.
- Enforces min on/off times, a max on time, an overcurrent trip and a bounded run duration, then drains the coil to zero before reporting done.

Parameters:
- MIN_ON, 8, minimum pwm-high cycles per pulse
- MIN_OFF, 8, minimum pwm-low cycles per pulse
- MAX_ON, 480, maximum pwm-high cycles per pulse (10 us at 48 MHz)
- ILIM, 12'sd1845, overcurrent trip level in DN (9 A at 205 DN/A)

Ports:
- clk  in  1  48 MHz system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle run request, honoured only in IDLE
- abort  in  1  level; forces DRAIN from ON/OFF
- fault_clr  in  1  single-cycle; clears FAULT
- run_len  in  24  run duration in clk cycles, sampled at start
- ipk  in  12  peak current target, unsigned DN
- ivl  in  12  valley current target, unsigned DN
- iest_coil  in  12  estimated coil current, ADC native format (current DN = iest_coil ^ 12'h7FF, signed)
- pwm  out  1  registered switch drive
- busy  out  1  high in ON/OFF/DRAIN
- done  out  1  one-cycle pulse on DRAIN->IDLE
- fault  out  1  high in FAULT
- cfg_err  out  1  sticky; start rejected because ipk <= ivl
- maxon_seen  out  1  sticky; at least one pulse terminated by MAX_ON
- pulse_cnt  out  16  ON entries since last accepted start, saturating at 16'hFFFF

Behaviour:
- Reset (async, active low): state=IDLE; every output 0; counters 0.
- i_meas = $signed(iest_coil ^ 12'h7FF). All comparisons are signed 13-bit, with ipk/ivl zero-extended.
- pwm is a registered decode of the next state: pwm=1 exactly in the cycles where state==ON. One clk latency from a qualifying sample to the pwm edge.
- run_tmr (24b) loads run_len on an accepted start. It decrements each cycle in ON/OFF and saturates at 0.
- IDLE:
  - start & abort -> stay IDLE.
  - start & ipk<=ivl -> set cfg_err, stay IDLE.
  - start, else: clear pulse_cnt, cfg_err, maxon_seen; go to OFF with off_cnt=MIN_OFF (first ON allowed immediately if i_meas<=ivl).
  - run_len==0 -> DRAIN.
- ON:
  - on_cnt counts from 0.
  - Exit to OFF when (on_cnt>=MIN_ON-1 & i_meas>=ipk), or when on_cnt==MAX_ON-1 (also sets maxon_seen).
- OFF:
  - off_cnt counts from 0.
  - If run_tmr==0 -> DRAIN.
  - Else if off_cnt>=MIN_OFF-1 & i_meas<=ivl -> ON; pulse_cnt++ (saturating).
- DRAIN: pwm=0. When i_meas<=0 -> IDLE with done=1 for one cycle.
- abort in ON/OFF -> DRAIN next cycle. abort in DRAIN/IDLE/FAULT has no effect.
- i_meas>=ILIM in any state -> FAULT next cycle, pwm=0. This check has priority over all other transitions.
- FAULT:
  - Held until fault_clr & i_meas<ILIM -> IDLE.
  - No done pulse. start is ignored.
- Simultaneous ON exit condition and run_tmr reaching 0: go to OFF first; DRAIN is taken from OFF.
- Counters saturate and never wrap. Changes to ipk/ivl during a run take effect on the next compare.

Test Plan:
- Nominal run: ipk=410, ivl=205, run_len=4800; bench model ramps +4 DN/cyc on, −2 DN/cyc off -> pwm toggles at i_meas=410/205, done after the coil reaches 0, pulse_cnt matches the observed pulses, no flags set.
- Min times: ipk=206, ivl=205, ramp ±20 DN/cyc -> every pwm high and low period is ≥8 cycles.
- Max on: ramp stuck at 100 DN -> pwm falls after exactly 480 high cycles, maxon_seen=1.
- Overcurrent: i_meas steps to 1900 mid-ON -> fault=1 and pwm=0 on the next edge. fault_clr with i_meas=1900 keeps FAULT; fault_clr with i_meas=0 goes to IDLE. start during FAULT is ignored.
- Config/abort: start with ipk=ivl=300 -> cfg_err=1, busy=0. start & abort in the same cycle -> stays IDLE. abort mid-OFF -> DRAIN, done when i_meas<=0.
- Async reset asserted mid-ON (between clk edges) -> pwm=0 immediately; all outputs 0 while reset is low.
